// File: rtl/pipe_pkg.sv
// Shared pipeline types for the hazard unit: destination-register shadow slot,
// forwarding-select encodings, instruction field positions and small helpers.
package pipe_pkg;

  localparam int SLOT_AW = 5;

  typedef struct packed {
    logic [SLOT_AW-1:0] td;
    logic               wr;
    logic               ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  // Writes to $0 are discarded by the register file, so they never mark a slot live.
  function automatic slot_t make_slot(input logic [SLOT_AW-1:0] td,
                                      input logic wreg,
                                      input logic lw);
    slot_t s;
    s.td = td;
    s.wr = wreg && (td != '0);
    s.ld = lw;
    return s;
  endfunction

  function automatic logic [1:0] fwd_select(input logic hit_ex,
                                            input logic hit_mem,
                                            input logic ex_ld);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (hit_ex && !ex_ld) begin
      sel = FWD_EXMEM;
    end else if (hit_mem) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage view of the hazard unit: decoded register usage in, stall/forward controls out.
interface hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16,
  parameter int REG_AW      = 5
);
  logic [31:0]            id_instr;
  logic                   id_use_rs;
  logic                   id_use_rt;
  logic [REG_AW-1:0]      id_td;
  logic                   id_WREG;
  logic                   id_LW;
  logic                   stall;
  logic                   pc_hold;
  logic [1:0]             fwd_a;
  logic [1:0]             fwd_b;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // The ID instruction is always "valid"; stall acts as the inverse of ready:
  // while stall=1 the instruction is not accepted into EX and must be held in ID.
  modport master (
    output id_instr, id_use_rs, id_use_rt, id_td, id_WREG, id_LW,
    input  stall, pc_hold, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_instr, id_use_rs, id_use_rt, id_td, id_WREG, id_LW,
    output stall, pc_hold, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/hazard_match.sv
// Combinational test of one source register against one in-flight destination slot.
module hazard_match
  import pipe_pkg::*;
(
  input  logic [SLOT_AW-1:0] src_i,
  input  logic               use_i,
  input  slot_t              slot_i,
  output logic               hit_o
);

  logic unused_ld;
  assign unused_ld = slot_i.ld;

  assign hit_o = use_i && (src_i != '0) && slot_i.wr && (slot_i.td == src_i);

endmodule

// File: rtl/hazard_ctrl.sv
// RAW hazard detection for the ID stage with stall, PC hold and a saturating stall counter.
// Define HAZARD_FORWARD_EN for registered EX operand forwarding and load-use-only stalls.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int STALL_CNT_W = 16,
  parameter int REG_AW      = 5
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  slot_t ex_s_q, ex_s_d;
  slot_t mem_s_q;
  slot_t wb_s_q;

  logic [REG_AW-1:0] rs, rt;
  logic              rs_ex, rs_mem, rt_ex, rt_mem;
  logic              stall;

  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  assign rs = bus.id_instr[RS_HI:RS_LO];
  assign rt = bus.id_instr[RT_HI:RT_LO];

  hazard_match u_rs_ex  (.src_i(rs), .use_i(bus.id_use_rs), .slot_i(ex_s_q),  .hit_o(rs_ex));
  hazard_match u_rs_mem (.src_i(rs), .use_i(bus.id_use_rs), .slot_i(mem_s_q), .hit_o(rs_mem));
  hazard_match u_rt_ex  (.src_i(rt), .use_i(bus.id_use_rt), .slot_i(ex_s_q),  .hit_o(rt_ex));
  hazard_match u_rt_mem (.src_i(rt), .use_i(bus.id_use_rt), .slot_i(mem_s_q), .hit_o(rt_mem));

  // WB never blocks: the register file writes on the falling edge, ahead of the ID read.
  always_comb begin
    ex_s_d = SLOT_EMPTY;
    if (!stall) begin
      ex_s_d = make_slot(bus.id_td, bus.id_WREG, bus.id_LW);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_s_q  <= SLOT_EMPTY;
      mem_s_q <= SLOT_EMPTY;
      wb_s_q  <= SLOT_EMPTY;
    end else begin
      ex_s_q  <= ex_s_d;
      mem_s_q <= ex_s_q;
      wb_s_q  <= mem_s_q;
    end
  end

`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  assign stall = (rs_ex || rt_ex) && ex_s_q.ld;

  always_comb begin
    fwd_a_d = FWD_NONE;
    fwd_b_d = FWD_NONE;
    if (!stall) begin
      fwd_a_d = fwd_select(rs_ex, rs_mem, ex_s_q.ld);
      fwd_b_d = fwd_select(rt_ex, rt_mem, ex_s_q.ld);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.fwd_a = fwd_a_q;
  assign bus.fwd_b = fwd_b_q;
`else
  assign stall     = rs_ex || rt_ex || rs_mem || rt_mem;
  assign bus.fwd_a = FWD_NONE;
  assign bus.fwd_b = FWD_NONE;
`endif

  assign bus.stall   = stall;
  assign bus.pc_hold = stall;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_cnt = cnt_q;

  logic unused_ok;
  assign unused_ok = ^{bus.id_instr[31:26], bus.id_instr[15:0], wb_s_q,
                       mem_s_q.ld, ex_s_q.ld};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus randomized traffic checked against
// an in-flight-instruction list model; a 4-bit-counter copy checks saturation.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 16;
  localparam int SAT_W = 4;
  localparam int SAT_MAX = (1 << SAT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.STALL_CNT_W(CNT_W), .REG_AW(5)) bus ();
  hazard_ctrl_if #(.STALL_CNT_W(SAT_W), .REG_AW(5)) sat_bus ();

  hazard_ctrl #(.STALL_CNT_W(CNT_W), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  hazard_ctrl #(.STALL_CNT_W(SAT_W), .REG_AW(5)) dut_sat (.clk(clk), .rst(rst), .bus(sat_bus));

  assign sat_bus.id_instr  = bus.id_instr;
  assign sat_bus.id_use_rs = bus.id_use_rs;
  assign sat_bus.id_use_rt = bus.id_use_rt;
  assign sat_bus.id_td     = bus.id_td;
  assign sat_bus.id_WREG   = bus.id_WREG;
  assign sat_bus.id_LW     = bus.id_LW;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // Reference model: list of in-flight instructions, index 0 = youngest (in EX).
  typedef struct { int td; bit wr; bit ld; } ent_t;
  ent_t hist[$];

  int n_cmp = 0;
  int n_fail = 0;
  bit m_stall;
  int exp_cnt;
  logic [1:0] exp_fa, exp_fb;
  int d_rs, d_rt, d_td;
  bit d_urs, d_urt, d_wreg, d_lw;

  function automatic int age_of(int src, bit use_it);
    if (!use_it || src == 0) return 0;
    for (int i = 0; i < 2; i++) begin
      if (hist[i].wr && hist[i].td == src) return i + 1;
    end
    return 0;
  endfunction

  function automatic bit model_stall();
    int a = age_of(d_rs, d_urs);
    int b = age_of(d_rt, d_urt);
    if (FWD) return (a == 1 || b == 1) && hist[0].ld;
    return (a != 0) || (b != 0);
  endfunction

  function automatic logic [1:0] model_fwd(int age);
    if (!FWD) return 2'b00;
    if (age == 1 && !hist[0].ld) return 2'b01;
    if (age == 2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_clear();
    ent_t z = '{td: 0, wr: 1'b0, ld: 1'b0};
    hist.delete();
    repeat (3) hist.push_back(z);
    exp_cnt = 0;
    exp_fa = 2'b00;
    exp_fb = 2'b00;
    m_stall = 1'b0;
  endfunction

  task automatic set_inputs(int rs, int rt, bit urs, bit urt, int td, bit wreg, bit lw);
    logic [31:0] ins;
    logic [31:0] rs_v, rt_v, td_v;
    ins = $urandom();
    rs_v = rs; rt_v = rt; td_v = td;
    ins[25:21] = rs_v[4:0];
    ins[20:16] = rt_v[4:0];
    d_rs = rs; d_rt = rt; d_urs = urs; d_urt = urt; d_td = td; d_wreg = wreg; d_lw = lw;
    bus.id_instr  = ins;
    bus.id_use_rs = urs;
    bus.id_use_rt = urt;
    bus.id_td     = td_v[4:0];
    bus.id_WREG   = wreg;
    bus.id_LW     = lw;
  endtask

  task automatic drive(int rs, int rt, bit urs, bit urt, int td, bit wreg, bit lw);
    @(negedge clk);
    set_inputs(rs, rt, urs, urt, td, wreg, lw);
    m_stall = model_stall();
    #1;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (m_stall) e = '{td: 0, wr: 1'b0, ld: 1'b0};
    else e = '{td: d_td, wr: d_wreg && (d_td != 0), ld: d_lw};
    exp_fa = m_stall ? 2'b00 : model_fwd(age_of(d_rs, d_urs));
    exp_fb = m_stall ? 2'b00 : model_fwd(age_of(d_rt, d_urt));
    if (m_stall) exp_cnt++;
    hist.push_front(e);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic release_reset();
    set_inputs(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    release_reset();
  endtask

  // Presents one instruction, holding it in ID while the DUT stalls.
  task automatic run_instr(int rs, int rt, bit urs, bit urt, int td, bit wreg, bit lw,
                           output int stalls);
    bit s;
    stalls = 0;
    for (int k = 0; k < 8; k++) begin
      drive(rs, rt, urs, urt, td, wreg, lw);
      s = bus.stall;
      if (s) stalls++;
      tick();
      if (!s) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL run_instr_timeout: instruction not issued after 8 cycles, stalls=%0d", stalls);
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    n_cmp++; if (bus.pc_hold !== 1'b0) begin n_fail++; $display("FAIL reset_pc_hold: got %b want 0", bus.pc_hold); end
    n_cmp++; if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0h want 0", bus.stall_cnt); end
    n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0) begin n_fail++; $display("FAIL reset_fwd: got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); end
    release_reset();
    drive(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    tick();
    drive(3, 4, 1'b1, 1'b0, 9, 1'b1, 1'b0);
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL midstall_enter: got %b want 1", bus.stall); end
    tick();
    n_cmp++; if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL midstall_cnt: got %0d want 1", bus.stall_cnt); end
    drive(3, 4, 1'b1, 1'b0, 9, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL async_rst_stall: got %b want 0", bus.stall); end
    n_cmp++; if (bus.pc_hold !== 1'b0) begin n_fail++; $display("FAIL async_rst_pc_hold: got %b want 0", bus.pc_hold); end
    n_cmp++; if (bus.stall_cnt !== '0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d want 0", bus.stall_cnt); end
    n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0) begin n_fail++; $display("FAIL async_rst_fwd: got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); end
    release_reset();
    drive(3, 3, 1'b1, 1'b1, 9, 1'b1, 1'b0);
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL post_rst_slots: got stall %b want 0", bus.stall); end
    tick();
  endtask

  task automatic test_raw_stall();
    int s1, s2, s3;
    apply_reset();
    run_instr(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0, s1);
    run_instr(3, 4, 1'b1, 1'b1, 9, 1'b1, 1'b0, s2);
    n_cmp++; if (s2 !== (FWD ? 0 : 2)) begin n_fail++; $display("FAIL raw_stall_cycles: got %0d want %0d", s2, FWD ? 0 : 2); end
    n_cmp++; if (bus.fwd_a !== (FWD ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL raw_fwd_a: got %b want %b", bus.fwd_a, FWD ? 2'b01 : 2'b00); end
    run_instr(10, 11, 1'b1, 1'b1, 12, 1'b1, 1'b0, s3);
    n_cmp++; if (s1 + s3 !== 0) begin n_fail++; $display("FAIL raw_neighbours: got %0d stalls want 0", s1 + s3); end
    n_cmp++; if (bus.stall_cnt !== (FWD ? 16'd0 : 16'd2)) begin n_fail++; $display("FAIL raw_cnt: got %0d want %0d", bus.stall_cnt, FWD ? 0 : 2); end
  endtask

  task automatic test_zero_reg();
    int s1, s2;
    apply_reset();
    run_instr(1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0, s1);
    run_instr(0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0, s2);
    n_cmp++; if (s1 + s2 !== 0) begin n_fail++; $display("FAIL zero_reg_stall: got %0d stalls want 0", s1 + s2); end
    n_cmp++; if ({bus.fwd_a, bus.fwd_b} !== 4'b0) begin n_fail++; $display("FAIL zero_reg_fwd: got %b/%b want 00/00", bus.fwd_a, bus.fwd_b); end
  endtask

  task automatic test_load_use();
    int s1, s2;
    apply_reset();
    run_instr(1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b1, s1);
    run_instr(1, 5, 1'b1, 1'b1, 6, 1'b1, 1'b0, s2);
    n_cmp++; if (s2 !== (FWD ? 1 : 2)) begin n_fail++; $display("FAIL load_use_cycles: got %0d want %0d", s2, FWD ? 1 : 2); end
    n_cmp++; if (bus.fwd_b !== (FWD ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL load_use_fwd_b: got %b want %b", bus.fwd_b, FWD ? 2'b10 : 2'b00); end
    n_cmp++; if (bus.fwd_a !== 2'b00) begin n_fail++; $display("FAIL load_use_fwd_a: got %b want 00", bus.fwd_a); end
  endtask

  task automatic test_fwd_paths();
    int s1, s2, s3;
    apply_reset();
    run_instr(1, 2, 1'b1, 1'b1, 7, 1'b1, 1'b0, s1);
    run_instr(1, 2, 1'b1, 1'b1, 8, 1'b1, 1'b0, s2);
    run_instr(7, 8, 1'b1, 1'b1, 9, 1'b1, 1'b0, s3);
    n_cmp++; if (s3 !== (FWD ? 0 : 2)) begin n_fail++; $display("FAIL dual_slot_cycles: got %0d want %0d", s3, FWD ? 0 : 2); end
    n_cmp++; if (bus.fwd_a !== (FWD ? 2'b10 : 2'b00)) begin n_fail++; $display("FAIL dual_fwd_a: got %b want %b", bus.fwd_a, FWD ? 2'b10 : 2'b00); end
    n_cmp++; if (bus.fwd_b !== (FWD ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL dual_fwd_b: got %b want %b", bus.fwd_b, FWD ? 2'b01 : 2'b00); end
  endtask

  task automatic test_saturation();
    int s, total;
    total = 0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      run_instr(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b1, s);
      total += s;
      run_instr(3, 3, 1'b1, 1'b1, 0, 1'b0, 1'b0, s);
      total += s;
    end
    n_cmp++; if (total !== (FWD ? 20 : 40)) begin n_fail++; $display("FAIL sat_total: got %0d want %0d", total, FWD ? 20 : 40); end
    n_cmp++; if (bus.stall_cnt !== (FWD ? 16'd20 : 16'd40)) begin n_fail++; $display("FAIL sat_wide_cnt: got %0d want %0d", bus.stall_cnt, FWD ? 20 : 40); end
    n_cmp++; if (sat_bus.stall_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_narrow_cnt: got %0h want f", sat_bus.stall_cnt); end
  endtask

  task automatic test_random();
    int rs, rt, td;
    bit urs, urt, wreg, lw;
    int sat_exp;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 0 || !m_stall) begin
        rs = $urandom_range(7, 0); rt = $urandom_range(7, 0); td = $urandom_range(7, 0);
        urs = $urandom_range(1, 0); urt = $urandom_range(1, 0);
        wreg = ($urandom_range(3, 0) != 0); lw = ($urandom_range(3, 0) == 0);
      end
      drive(rs, rt, urs, urt, td, wreg, lw);
      n_cmp++; if (bus.stall !== m_stall) begin n_fail++; $display("FAIL rand_stall c=%0d: got %b want %b", c, bus.stall, m_stall); end
      n_cmp++; if (bus.pc_hold !== m_stall) begin n_fail++; $display("FAIL rand_pc_hold c=%0d: got %b want %b", c, bus.pc_hold, m_stall); end
      tick();
      sat_exp = (exp_cnt > SAT_MAX) ? SAT_MAX : exp_cnt;
      n_cmp++; if (bus.stall_cnt !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, bus.stall_cnt, exp_cnt); end
      n_cmp++; if (sat_bus.stall_cnt !== SAT_W'(sat_exp)) begin n_fail++; $display("FAIL rand_sat_cnt c=%0d: got %0d want %0d", c, sat_bus.stall_cnt, sat_exp); end
      n_cmp++; if (bus.fwd_a !== exp_fa) begin n_fail++; $display("FAIL rand_fwd_a c=%0d: got %b want %b", c, bus.fwd_a, exp_fa); end
      n_cmp++; if (bus.fwd_b !== exp_fb) begin n_fail++; $display("FAIL rand_fwd_b c=%0d: got %b want %b", c, bus.fwd_b, exp_fb); end
    end
  endtask

  initial begin
    rst = 1'b0;
    set_inputs(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    model_clear();
    #12;
    test_reset();
    test_raw_stall();
    test_zero_reg();
    test_load_use();
    test_fwd_paths();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
